// File: rtl/multdiv_wb_pkg.sv
// Shared types and constants for the mul/div writeback/interlock stage.
package multdiv_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_MUL     = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;

endpackage

// File: rtl/multdiv_wb_watchdog.sv
// Busy-cycle counter for the mul/div writeback stage; expire marks the
// WDOG_CYCLES-th consecutive cycle spent waiting. Built only with MULTDIV_WB_WATCHDOG_EN.
module multdiv_wb_watchdog #(
  parameter int WDOG_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Counter restarts from zero every time the stage enters the waiting state.
  always_ff @(posedge clock) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (!expire) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = run && (cnt == CW'(WDOG_CYCLES - 1));

endmodule

// File: rtl/multdiv_wb.sv
// Mul/div writeback and decode interlock: tracks one in-flight op, writes its
// result (or rstatus code) through the shared port. Optional macro: MULTDIV_WB_WATCHDOG_EN.
module multdiv_wb
  import multdiv_wb_pkg::*;
#(
  parameter int WDOG_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic        dec_uses_rs,
  input  logic        dec_uses_rt,
  input  logic        dec_wen,
  input  logic [4:0]  dec_rd,
  input  logic        dec_is_md,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        stall,
  output logic        busy,
  output logic        wdog_fired
);

  state_e      state_q, state_d;
  logic [4:0]  rd_q;
  logic        is_div_q;
  logic [4:0]  hold_rd;
  logic [31:0] hold_data;
  logic        wdog_expire;

`ifdef MULTDIV_WB_WATCHDOG_EN
  multdiv_wb_watchdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .run    (state_q == ST_BUSY),
    .expire (wdog_expire)
  );
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES > 0);
  assign wdog_expire     = 1'b0;
`endif

  // A real md_ready always wins over a same-cycle watchdog expiry.
  logic        done, is_exc;
  logic [4:0]  done_rd;
  logic [31:0] done_data;

  assign done      = (state_q == ST_BUSY) && (md_ready || wdog_expire);
  assign is_exc    = md_ready ? md_exception : 1'b1;
  assign done_rd   = is_exc ? RSTATUS_REG : rd_q;
  assign done_data = is_exc ? (is_div_q ? EXC_DIV : EXC_MUL) : md_result;

  logic rd_nz, hazard;
  assign rd_nz  = (rd_q != 5'd0);
  assign hazard = (dec_uses_rs && rd_nz && dec_rs == rd_q)
               || (dec_uses_rt && rd_nz && dec_rt == rd_q)
               || (dec_wen     && rd_nz && dec_rd == rd_q)
               || dec_is_md
               || (dec_uses_rs && dec_rs == RSTATUS_REG)
               || (dec_uses_rt && dec_rt == RSTATUS_REG);

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    rf_wen     = pipe_wen;
    rf_rd      = pipe_rd;
    rf_data    = pipe_data;
    stall      = 1'b0;
    wdog_fired = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (issue_valid) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        stall = hazard;
        if (done) begin
          wdog_fired = !md_ready;
          if (pipe_wen) begin
            state_d = ST_HOLD;
          end else begin
            rf_wen  = (done_rd != 5'd0);
            rf_rd   = done_rd;
            rf_data = done_data;
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        stall   = 1'b1;
        rf_wen  = (hold_rd != 5'd0);
        rf_rd   = hold_rd;
        rf_data = hold_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      hold_rd   <= '0;
      hold_data <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && issue_valid) begin
        rd_q     <= issue_rd;
        is_div_q <= issue_is_div;
      end
      if (done && pipe_wen) begin
        hold_rd   <= done_rd;
        hold_data <= done_data;
      end
    end
  end

endmodule
